// File: rtl/idma_axi_write_pkg.sv
// idma_axi_write_pkg: shared AXI4 types, FSM state encodings and constants for the write issuer
package idma_axi_write_pkg;
  localparam int unsigned AXI_AW = 32;
  localparam int unsigned AXI_DW = 32;
  localparam int unsigned AXI_IW = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AW = 2'd1;
  localparam logic [1:0] ST_W = 2'd2;
  function automatic logic [2:0] size_from_width(input int unsigned width);
    return 3'($clog2(width / 8));
  endfunction
  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } axi_ax_t;
  typedef struct packed {
    logic [AXI_DW-1:0] data;
    logic [AXI_DW/8-1:0] strb;
    logic last;
  } axi_w_t;
  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0] resp;
  } axi_b_t;
  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0] resp;
    logic last;
  } axi_r_t;
  typedef struct packed {
    axi_ax_t aw;
    logic aw_valid;
    axi_w_t w;
    logic w_valid;
    logic b_ready;
    axi_ax_t ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    axi_b_t b;
    logic b_valid;
    axi_r_t r;
    logic r_valid;
  } axi_rsp_t;
endpackage

// File: rtl/idma_axi_write_rsp_buf.sv
// idma_axi_write_rsp_buf: one-entry valid/ready holding register for {id, err} burst responses
module idma_axi_write_rsp_buf #(
  parameter int unsigned IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IdWidth-1:0] in_id_i,
  input  logic               in_err_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [IdWidth-1:0] out_id_o,
  output logic               out_err_o
);
  logic valid_q, valid_d, err_q, err_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic in_hs;
  assign in_ready_o = rst_ni && (!valid_q || out_ready_i);
  assign in_hs = in_valid_i && in_ready_o;
  assign valid_d = in_hs || (valid_q && !out_ready_i);
  assign id_d = in_hs ? in_id_i : id_q;
  assign err_d = in_hs ? in_err_i : err_q;
  assign out_valid_o = valid_q;
  assign out_id_o = id_q;
  assign out_err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q <= '0;
      err_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q <= id_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/idma_axi_write_issuer.sv
// idma_axi_write_issuer: turns a write command plus beat stream into one AXI4 AW burst,
// len+1 W beats and B tracking with up to MaxOutstanding bursts in flight.
module idma_axi_write_issuer
  import idma_axi_write_pkg::*;
#(
  parameter type         axi_req_t      = idma_axi_write_pkg::axi_req_t,
  parameter type         axi_rsp_t      = idma_axi_write_pkg::axi_rsp_t,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [7:0]             cmd_len_i,
  input  logic [AxiIdWidth-1:0]  cmd_id_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [DataWidth-1:0]   data_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output axi_req_t               axi_req_o,
  input  axi_rsp_t               axi_rsp_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [AxiIdWidth-1:0]  rsp_id_o,
  output logic                   rsp_err_o,
  output logic                   busy_o
);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);
  logic [1:0] state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, beat_q, beat_d;
  logic [AxiIdWidth-1:0] id_q, id_d;
  logic [OutW-1:0] out_q, out_d;
  logic cmd_hs, aw_hs, w_hs, w_last, b_ready, b_hs, unused;
  assign cmd_ready_o = rst_ni && state_q == ST_IDLE && out_q < MaxOut;
  assign cmd_hs = cmd_valid_i && cmd_ready_o;
  assign aw_hs = state_q == ST_AW && axi_rsp_i.aw_ready;
  assign w_last = beat_q == len_q;
  assign w_hs = state_q == ST_W && data_valid_i && axi_rsp_i.w_ready;
  assign b_hs = axi_rsp_i.b_valid && b_ready;
  assign data_ready_o = state_q == ST_W && axi_rsp_i.w_ready;
  assign busy_o = state_q != ST_IDLE || out_q != '0;
  assign unused = ^{axi_rsp_i.ar_ready, axi_rsp_i.r_valid, axi_rsp_i.r};
  assign state_d = cmd_hs ? ST_AW : aw_hs ? ST_W : (w_hs && w_last) ? ST_IDLE : state_q;
  assign addr_d = cmd_hs ? cmd_addr_i : addr_q;
  assign len_d = cmd_hs ? cmd_len_i : len_q;
  assign id_d = cmd_hs ? cmd_id_i : id_q;
  assign beat_d = aw_hs ? 8'd0 : w_hs ? beat_q + 8'd1 : beat_q;
  // a stray B at zero outstanding leaves the counter at zero instead of wrapping
  assign out_d = (aw_hs && !b_hs) ? out_q + 1'b1
               : (b_hs && !aw_hs && out_q != '0) ? out_q - 1'b1 : out_q;
  always_comb begin
    axi_req_o = '0;
    if (state_q == ST_AW) begin
      axi_req_o.aw.id = id_q;
      axi_req_o.aw.addr = addr_q;
      axi_req_o.aw.len = len_q;
      axi_req_o.aw.size = size_from_width(DataWidth);
      axi_req_o.aw.burst = AXI_BURST_INCR;
      axi_req_o.aw_valid = 1'b1;
    end
    axi_req_o.w.data = state_q == ST_W ? data_i : '0;
    axi_req_o.w.strb = state_q == ST_W ? strb_i : '0;
    axi_req_o.w.last = state_q == ST_W && w_last;
    axi_req_o.w_valid = state_q == ST_W && data_valid_i;
    axi_req_o.b_ready = b_ready;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      len_q <= '0;
      id_q <= '0;
      beat_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      id_q <= id_d;
      beat_q <= beat_d;
      out_q <= out_d;
    end
  end
  idma_axi_write_rsp_buf #(.IdWidth(AxiIdWidth)) i_rsp_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (axi_rsp_i.b_valid),
    .in_ready_o  (b_ready),
    .in_id_i     (axi_rsp_i.b.id),
    .in_err_i    (axi_rsp_i.b.resp != RESP_OKAY),
    .out_valid_o (rsp_valid_o),
    .out_ready_i (rsp_ready_i),
    .out_id_o    (rsp_id_o),
    .out_err_o   (rsp_err_o)
  );
  a_b_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni) b_hs |-> out_q != '0);
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cmd_hs |-> (32'(cmd_addr_i) & (DataWidth / 8 - 1)) == 32'd0);
  a_no_4k_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cmd_hs |-> {20'd0, cmd_addr_i[11:0]} + ({24'd0, cmd_len_i} + 32'd1) * (DataWidth / 8) <= 32'd4096);
endmodule

// File: tb/tb_idma_axi_write_issuer.sv
// tb_idma_axi_write_issuer: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_idma_axi_write_issuer;
  import idma_axi_write_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, cmd_valid, cmd_ready, data_valid, data_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] cmd_addr, data;
  logic [7:0] cmd_len;
  logic [3:0] cmd_id, strb, rsp_id;
  axi_req_t req;
  axi_rsp_t rsp;
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] addr; logic [7:0] len; logic [3:0] id;} aw_exp_t;
  typedef struct {logic [31:0] data; logic [3:0] strb; logic last;} w_exp_t;
  typedef struct {logic [3:0] id; logic err;} r_exp_t;
  aw_exp_t exp_aw[$];
  w_exp_t exp_w[$];
  r_exp_t exp_rsp[$];
  idma_axi_write_issuer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
    .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data), .strb_i(strb),
    .axi_req_o(req), .axi_rsp_i(rsp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err), .busy_o(busy)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  // scoreboard monitor: pops an expectation for every handshake the DUT presents
  aw_exp_t ea;
  w_exp_t ew;
  r_exp_t er;
  axi_ax_t prev_aw;
  logic prev_awv = 1'b0, prev_awr = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (prev_awv && !prev_awr) begin
        chk("aw_valid_stable", req.aw_valid, 1);
        chk("aw_payload_stable", req.aw, prev_aw);
      end
      if (req.aw_valid && rsp.aw_ready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          ea = exp_aw.pop_front();
          chk("aw_addr", req.aw.addr, ea.addr);
          chk("aw_len", req.aw.len, ea.len);
          chk("aw_id", req.aw.id, ea.id);
          chk("aw_size", req.aw.size, 3'd2);
          chk("aw_burst", req.aw.burst, 2'd1);
        end
      end
      if (req.w_valid && rsp.w_ready) begin
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          ew = exp_w.pop_front();
          chk("w_data", req.w.data, ew.data);
          chk("w_strb", req.w.strb, ew.strb);
          chk("w_last", req.w.last, ew.last);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          er = exp_rsp.pop_front();
          chk("rsp_id", rsp_id, er.id);
          chk("rsp_err", rsp_err, er.err);
        end
      end
      prev_awv = req.aw_valid;
      prev_awr = rsp.aw_ready;
      prev_aw = req.aw;
    end else prev_awv = 1'b0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy(input int sel, input string name);
    int n = 0;
    logic hs = 1'b0;
    while (!hs && n < 60) begin
      @(negedge clk);
      hs = sel == 0 ? cmd_ready : sel == 1 ? data_ready : req.b_ready;
      tick();
      n++;
    end
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_ready exp=ready", name);
    end
  endtask
  task automatic do_cmd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i);
    exp_aw.push_back('{a, l, i});
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_id = i;
    wait_rdy(0, "cmd");
    cmd_valid = 1'b0;
  endtask
  task automatic do_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    exp_w.push_back('{d, s, last});
    data_valid = 1'b1; data = d; strb = s;
    wait_rdy(1, "beat");
    data_valid = 1'b0;
  endtask
  task automatic do_b(input logic [3:0] i, input logic [1:0] r);
    exp_rsp.push_back('{i, r != 2'd0});
    rsp.b_valid = 1'b1; rsp.b.id = i; rsp.b.resp = r;
    wait_rdy(2, "b");
    rsp.b_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    data_valid = 1'b0; data = '0; strb = '0; rsp = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_req_zero", req == '0, 1);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_data_ready", data_ready, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_id}, 0);
    chk("reset_busy", busy, 0);
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1; rsp.aw_ready = 1'b1; rsp.w_ready = 1'b1;
    tick();
    // single-beat burst
    do_cmd(32'h1000, 8'd0, 4'd3);
    do_beat(32'hDEADBEEF, 4'hF, 1'b1);
    do_b(4'd3, 2'd0);
    repeat (3) tick();
    chk("t1_idle_busy", busy, 0);
    // 8-beat burst with AW stalled and gapped data
    rsp.aw_ready = 1'b0;
    do_cmd(32'h2000, 8'd7, 4'd5);
    repeat (5) begin
      @(negedge clk);
      chk("t2_aw_held", req.aw_valid, 1);
      chk("t2_no_w_before_aw", req.w_valid, 0);
      tick();
    end
    rsp.aw_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_beat(32'hA5000000 + k, 4'(k + 1), k == 7);
      tick();
    end
    do_b(4'd5, 2'd0);
    // outstanding limit
    for (int k = 0; k < 4; k++) begin
      do_cmd(32'h5000 + k * 32'h100, 8'd0, 4'(k + 1));
      do_beat(32'hC0 + k, 4'hF, 1'b1);
    end
    tick();
    chk("t3_out_full", dut.out_q, 4);
    exp_aw.push_back('{32'h5400, 8'd0, 4'd5});
    cmd_valid = 1'b1; cmd_addr = 32'h5400; cmd_len = 8'd0; cmd_id = 4'd5;
    repeat (4) begin
      @(negedge clk);
      chk("t3_cmd_blocked", cmd_ready, 0);
      tick();
    end
    do_b(4'd1, 2'd0);
    wait_rdy(0, "cmd5");
    cmd_valid = 1'b0;
    do_beat(32'hC4, 4'h3, 1'b1);
    for (int k = 2; k <= 5; k++) do_b(4'(k), 2'd0);
    // SLVERR held in the response port while a second B waits
    do_cmd(32'h6000, 8'd0, 4'd6);
    do_beat(32'h66, 4'hF, 1'b1);
    do_cmd(32'h6100, 8'd0, 4'd7);
    do_beat(32'h77, 4'hF, 1'b1);
    rsp_ready = 1'b0;
    do_b(4'd6, 2'd2);
    fork
      do_b(4'd7, 2'd0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t4_b_ready_stall", req.b_ready, 0);
          chk("t4_rsp_held", {rsp_valid, rsp_err, rsp_id}, {1'b1, 1'b1, 4'd6});
          tick();
        end
        rsp_ready = 1'b1;
      end
    join
    repeat (3) tick();
    // coincident AW and B handshakes
    do_cmd(32'h7000, 8'd0, 4'd1);
    do_beat(32'h71, 4'hF, 1'b1);
    do_cmd(32'h7100, 8'd0, 4'd2);
    do_beat(32'h72, 4'hF, 1'b1);
    rsp.aw_ready = 1'b0;
    do_cmd(32'h7200, 8'd0, 4'd3);
    chk("t5_out_before", dut.out_q, 2);
    rsp.aw_ready = 1'b1;
    exp_rsp.push_back('{4'd1, 1'b0});
    rsp.b_valid = 1'b1; rsp.b.id = 4'd1; rsp.b.resp = 2'd0;
    @(negedge clk);
    chk("t5_coincident", {req.aw_valid, rsp.aw_ready, rsp.b_valid, req.b_ready}, 4'hF);
    tick();
    rsp.b_valid = 1'b0;
    @(negedge clk);
    chk("t5_out_after", dut.out_q, 2);
    chk("t5_busy", busy, 1);
    tick();
    do_beat(32'h73, 4'hF, 1'b1);
    do_b(4'd2, 2'd0);
    do_b(4'd3, 2'd0);
    repeat (3) tick();
    chk("t5_drained", {busy, dut.out_q}, 0);
    // reset in the middle of a burst
    do_cmd(32'h8000, 8'd7, 4'd9);
    for (int k = 0; k < 3; k++) do_beat(32'h80 + k, 4'hF, 1'b0);
    data_valid = 1'b1; data = 32'h83; strb = 4'hF;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_req_zero", req == '0, 1);
    chk("t6_state_idle", dut.state_q, 0);
    chk("t6_out_zero", dut.out_q, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    tick();
    data_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    do_cmd(32'h9000, 8'd1, 4'd10);
    do_beat(32'h90, 4'hF, 1'b0);
    do_beat(32'h91, 4'h1, 1'b1);
    do_b(4'd10, 2'd0);
    repeat (4) tick();
    chk("t6_final_busy", busy, 0);
    chk("queues_empty", exp_aw.size() + exp_w.size() + exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
